line_buffer_chain: RTL and testbench

- Parametrised multi-line buffer for the preparation module.
- Stores NUM_LINES previous image lines of a raster pixel stream.
- For every accepted pixel, presents a vertical column of NUM_LINES+1 pixels at the same x position (current line plus the NUM_LINES lines above), ready for downstream window/kernel generators.
- Line length is selectable per frame at runtime, up to LINE_WIDTH.

---
 rtl/line_buffer_chain.sv | 138 +++++++++++++
 tb/tb_line_buffer_chain.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_chain.sv
// Multi-line raster buffer: keeps NUM_LINES previous lines and emits, one cycle
// after each accepted pixel, the vertical column at the same x position.
module line_buffer_chain #(
    parameter int DATA_WIDTH = 8,
    parameter int LINE_WIDTH = 640,
    parameter int NUM_LINES  = 2,
    parameter int CNT_WIDTH  = 10
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  sof_i,
    input  logic                                  valid_i,
    input  logic [DATA_WIDTH-1:0]                 data_i,
    input  logic [CNT_WIDTH-1:0]                  line_len_i,
    output logic [DATA_WIDTH*(NUM_LINES+1)-1:0]   column_o,
    output logic                                  col_valid_o,
    output logic [CNT_WIDTH-1:0]                  col_x_o,
    output logic [CNT_WIDTH-1:0]                  lines_o
);

    localparam int ADDR_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int COL_W  = DATA_WIDTH * (NUM_LINES + 1);
    localparam logic [CNT_WIDTH-1:0] MAX_LEN    = CNT_WIDTH'(LINE_WIDTH);
    localparam logic [CNT_WIDTH-1:0] FULL_LINES = CNT_WIDTH'(NUM_LINES);

    // Handshake: a pixel is accepted on any rising edge where valid_i=1 and
    // either a frame is open or sof_i opens one in the same cycle; there is no
    // backpressure. col_valid_o qualifies column_o/col_x_o for exactly one cycle.
    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t                        state_q, state_d;
    logic [CNT_WIDTH-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CNT_WIDTH-1:0]          len_q, len_d;
    logic [CNT_WIDTH-1:0]          lines_q, lines_d;
    logic [CNT_WIDTH-1:0]          col_x_q, col_x_d;
    logic [COL_W-1:0]              column_q, column_d;
    logic                          col_valid_q, col_valid_d;

    logic                          accept;
    logic [CNT_WIDTH-1:0]          ptr_cur, lines_cur, len_cur;
    logic [ADDR_W-1:0]             addr;
    logic [DATA_WIDTH*NUM_LINES-1:0] old_flat;

    // sof_i restarts the frame in the same cycle, so a co-incident pixel sees x=0.
    always_comb begin
        len_cur   = len_q;
        ptr_cur   = wr_ptr_q;
        lines_cur = lines_q;
        if (sof_i) begin
            if (line_len_i == '0 || line_len_i > MAX_LEN) begin
                len_cur = MAX_LEN;
            end else begin
                len_cur = line_len_i;
            end
            ptr_cur   = '0;
            lines_cur = '0;
        end
    end

    assign accept = valid_i && (sof_i || (state_q != IDLE));
    assign addr   = ptr_cur[ADDR_W-1:0];

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = ptr_cur;
        len_d       = len_cur;
        lines_d     = lines_cur;
        col_x_d     = col_x_q;
        column_d    = column_q;
        col_valid_d = 1'b0;
        if (sof_i) begin
            state_d = FILL;
        end
        if (accept) begin
            column_d    = {old_flat, data_i};
            col_x_d     = ptr_cur;
            col_valid_d = (lines_cur == FULL_LINES);
            if (ptr_cur == len_cur - 1'b1) begin
                wr_ptr_d = '0;
                if (lines_cur != FULL_LINES) begin
                    lines_d = lines_cur + 1'b1;
                end
            end else begin
                wr_ptr_d = ptr_cur + 1'b1;
            end
        end
        if (state_d != IDLE) begin
            state_d = (lines_d == FULL_LINES) ? RUN : FILL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            len_q       <= MAX_LEN;
            lines_q     <= '0;
            col_x_q     <= '0;
            column_q    <= '0;
            col_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            len_q       <= len_d;
            lines_q     <= lines_d;
            col_x_q     <= col_x_d;
            column_q    <= column_d;
            col_valid_q <= col_valid_d;
        end
    end

    // Each line memory reads old data combinationally and writes on the edge,
    // so the cascade shifts line k-1 into line k at the same x.
    for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
        logic [DATA_WIDTH-1:0] mem [LINE_WIDTH];
        logic [DATA_WIDTH-1:0] wdata;

        assign old_flat[k*DATA_WIDTH +: DATA_WIDTH] = mem[addr];

        if (k == 0) begin : g_head
            assign wdata = data_i;
        end else begin : g_tail
            assign wdata = old_flat[(k-1)*DATA_WIDTH +: DATA_WIDTH];
        end

        always_ff @(posedge clk) begin
            if (accept) begin
                mem[addr] <= wdata;
            end
        end
    end

    assign column_o    = column_q;
    assign col_valid_o = col_valid_q;
    assign col_x_o     = col_x_q;
    assign lines_o     = lines_q;

endmodule

// File: tb/tb_line_buffer_chain.sv
// Directed bench for line_buffer_chain with NUM_LINES=2, LINE_WIDTH=8.
module tb_line_buffer_chain;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sof_i = 1'b0;
  logic          valid_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic [CW-1:0] line_len_i = '0;
  logic [3*DW-1:0] column_o;
  logic          col_valid_o;
  logic [CW-1:0] col_x_o;
  logic [CW-1:0] lines_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  line_buffer_chain #(
    .DATA_WIDTH(DW),
    .LINE_WIDTH(8),
    .NUM_LINES(2),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sof_i(sof_i),
    .valid_i(valid_i),
    .data_i(data_i),
    .line_len_i(line_len_i),
    .column_o(column_o),
    .col_valid_o(col_valid_o),
    .col_x_o(col_x_o),
    .lines_o(lines_o)
  );

  // clock block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver: apply one cycle of inputs at negedge, return 1 ns after the next posedge
  task automatic step(input logic s, input logic v, input logic [DW-1:0] d, input logic [CW-1:0] len);
    @(negedge clk);
    sof_i = s;
    valid_i = v;
    data_i = d;
    line_len_i = len;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    vec_cnt++;
    if ({column_o, col_valid_o, col_x_o, lines_o} !== '0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got col=%h v=%b x=%0d l=%0d, want all 0", column_o, col_valid_o, col_x_o, lines_o);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, DW'(8'hA0 + i), 4'd4);
      vec_cnt++;
      if (col_valid_o !== 1'b0 || lines_o !== 4'd0 || column_o !== '0 || col_x_o !== 4'd0) begin
        err_cnt++;
        $display("FAIL idle_ignore: got col=%h v=%b x=%0d l=%0d, want 0 0 0 0", column_o, col_valid_o, col_x_o, lines_o);
      end
    end
  endtask

  task automatic test_fill_run;
    logic [3*DW-1:0] exp_col;
    for (int p = 1; p <= 12; p++) begin
      step(p == 1, 1'b1, DW'(p), 4'd4);
      exp_col = {DW'(p - 8), DW'(p - 4), DW'(p)};
      vec_cnt++;
      if (col_valid_o !== (p >= 9)) begin
        err_cnt++;
        $display("FAIL fill_valid p=%0d: got %b want %b", p, col_valid_o, (p >= 9));
      end
      vec_cnt++;
      if (col_x_o !== CW'((p - 1) % 4) || column_o[DW-1:0] !== DW'(p)) begin
        err_cnt++;
        $display("FAIL fill_x p=%0d: got x=%0d s0=%0d want x=%0d s0=%0d", p, col_x_o, column_o[DW-1:0], (p - 1) % 4, p);
      end
      vec_cnt++;
      if (lines_o !== CW'((p / 4 > 2) ? 2 : p / 4)) begin
        err_cnt++;
        $display("FAIL fill_lines p=%0d: got %0d want %0d", p, lines_o, (p / 4 > 2) ? 2 : p / 4);
      end
      if (p >= 9) begin
        vec_cnt++;
        if (column_o !== exp_col) begin
          err_cnt++;
          $display("FAIL fill_column p=%0d: got %h want %h", p, column_o, exp_col);
        end
      end
    end
  endtask

  task automatic test_gaps;
    logic [3*DW-1:0] exp_col;
    for (int p = 1; p <= 12; p++) begin
      step(p == 1, 1'b1, DW'(p), 4'd4);
      exp_col = {DW'(p - 8), DW'(p - 4), DW'(p)};
      vec_cnt++;
      if (col_valid_o !== (p >= 9) || col_x_o !== CW'((p - 1) % 4) || column_o[DW-1:0] !== DW'(p)) begin
        err_cnt++;
        $display("FAIL gap_pixel p=%0d: got v=%b x=%0d s0=%0d", p, col_valid_o, col_x_o, column_o[DW-1:0]);
      end
      if (p >= 9) begin
        vec_cnt++;
        if (column_o !== exp_col) begin
          err_cnt++;
          $display("FAIL gap_column p=%0d: got %h want %h", p, column_o, exp_col);
        end
      end
      step(1'b0, 1'b0, 8'hEE, 4'd4);
      vec_cnt++;
      if (col_valid_o !== 1'b0 || col_x_o !== CW'((p - 1) % 4) || column_o[DW-1:0] !== DW'(p)) begin
        err_cnt++;
        $display("FAIL gap_idle p=%0d: got v=%b x=%0d s0=%0d want 0 %0d %0d", p, col_valid_o, col_x_o, column_o[DW-1:0], (p - 1) % 4, p);
      end
    end
  endtask

  task automatic test_sof_restart;
    logic [3*DW-1:0] exp_col;
    for (int p = 1; p <= 10; p++) begin
      step(p == 1, 1'b1, DW'(p), 4'd4);
    end
    for (int p = 11; p <= 22; p++) begin
      step(p == 11, 1'b1, DW'(p), 4'd4);
      exp_col = {DW'(p - 8), DW'(p - 4), DW'(p)};
      vec_cnt++;
      if (col_valid_o !== (p >= 19) || col_x_o !== CW'((p - 11) % 4)) begin
        err_cnt++;
        $display("FAIL restart_valid p=%0d: got v=%b x=%0d want v=%b x=%0d", p, col_valid_o, col_x_o, (p >= 19), (p - 11) % 4);
      end
      if (p >= 19) begin
        vec_cnt++;
        if (column_o !== exp_col) begin
          err_cnt++;
          $display("FAIL restart_column p=%0d: got %h want %h", p, column_o, exp_col);
        end
      end
    end
  endtask

  // len_val 0 selects the full line; 12 exceeds LINE_WIDTH and clamps to 8
  task automatic test_full_len(input logic [CW-1:0] len_val);
    logic [3*DW-1:0] exp_col;
    for (int p = 1; p <= 24; p++) begin
      step(p == 1, 1'b1, DW'(p), len_val);
      exp_col = {DW'(p - 16), DW'(p - 8), DW'(p)};
      vec_cnt++;
      if (col_valid_o !== (p >= 17) || col_x_o !== CW'((p - 1) % 8)) begin
        err_cnt++;
        $display("FAIL full_len%0d_valid p=%0d: got v=%b x=%0d want v=%b x=%0d", len_val, p, col_valid_o, col_x_o, (p >= 17), (p - 1) % 8);
      end
      if (p >= 17) begin
        vec_cnt++;
        if (column_o !== exp_col) begin
          err_cnt++;
          $display("FAIL full_len%0d_column p=%0d: got %h want %h", len_val, p, column_o, exp_col);
        end
      end
    end
  endtask

  task automatic test_async_reset;
    logic [3*DW-1:0] exp_col;
    for (int p = 1; p <= 9; p++) begin
      step(p == 1, 1'b1, DW'(p), 4'd4);
    end
    @(negedge clk);
    sof_i = 1'b0;
    valid_i = 1'b1;
    data_i = 8'd10;
    #1 rst = 1'b1;
    #1;
    vec_cnt++;
    if ({column_o, col_valid_o, col_x_o, lines_o} !== '0) begin
      err_cnt++;
      $display("FAIL async_reset: got col=%h v=%b x=%0d l=%0d, want all 0", column_o, col_valid_o, col_x_o, lines_o);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    vec_cnt++;
    if (col_valid_o !== 1'b0 || lines_o !== 4'd0 || column_o !== '0) begin
      err_cnt++;
      $display("FAIL post_reset_idle: got v=%b l=%0d col=%h, want 0 0 0", col_valid_o, lines_o, column_o);
    end
    for (int p = 1; p <= 12; p++) begin
      step(p == 1, 1'b1, DW'(p), 4'd4);
      exp_col = {DW'(p - 8), DW'(p - 4), DW'(p)};
      vec_cnt++;
      if (col_valid_o !== (p >= 9) || col_x_o !== CW'((p - 1) % 4) || lines_o !== CW'((p / 4 > 2) ? 2 : p / 4)) begin
        err_cnt++;
        $display("FAIL rerun_ctrl p=%0d: got v=%b x=%0d l=%0d", p, col_valid_o, col_x_o, lines_o);
      end
      if (p >= 9) begin
        vec_cnt++;
        if (column_o !== exp_col) begin
          err_cnt++;
          $display("FAIL rerun_column p=%0d: got %h want %h", p, column_o, exp_col);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_run();
    test_gaps();
    test_sof_restart();
    test_full_len(4'd0);
    test_full_len(4'd12);
    test_async_reset();
    step(1'b0, 1'b0, '0, '0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
